// File: rtl/controller_pkg.sv
// controller_pkg: shared encodings for the multi-cycle RISC-V controller.
// Holds the sequencer state enum, the supported opcodes and the
// encodings of the ALUOp / ResultSrc / ALUSrcA / ALUSrcB selects.
package controller_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// main_fsm: multi-cycle Moore sequencer for the RISC-V controller.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath enables and mux selects. FETCH, MEMREAD and MEMWRITE
// stall on mem_ready so a slow unified memory can hold the sequence.
// Ports:
//   clk, reset (async, active low)
//   op         instr[6:0] from the IR (sampled in DECODE and MEMADR)
//   mem_ready  memory access completes this cycle
//   Branch, PCUpdate, RegWrite, MemWrite, IRWrite  datapath strobes
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp     datapath selects
//   illegal_op one-cycle pulse on an unsupported opcode in DECODE
//   state      current state encoding for debug/trace
module main_fsm
    import controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output logic       Branch,
    output logic       PCUpdate,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    statetype state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // Next-state logic
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW)      state_d = MEMREAD;
                else if (op == OP_SW) state_d = MEMWRITE;
                else                  state_d = FETCH;
            end
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    // Output decode. Outputs depend on mem_ready in the stalling states, so
    // they are decoded from the state register rather than registered.
    always_comb begin
        Branch     = 1'b0;
        PCUpdate   = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            DECODE: begin
                // Branch target precompute: OldPC + ImmExt
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_op = 1'b0;
                    default:                                 illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            MEMREAD: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                ResultSrc = RES_ALUOUT;
                AdrSrc    = 1'b1;
                MemWrite  = mem_ready;
            end
            EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            BEQ: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUOp     = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                Branch    = 1'b1;
            end
            JAL: begin
                // ALU forms OldPC+4 for the link; ALUOut (jump target) goes to PC
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
                ResultSrc = RES_ALUOUT;
                PCUpdate  = 1'b1;
            end
            default: ;
        endcase

        // While reset is held no strobe may fire, even before the async clear
        // of the state register has propagated; selects show FETCH values.
        if (!reset) begin
            Branch     = 1'b0;
            PCUpdate   = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            illegal_op = 1'b0;
            AdrSrc     = 1'b0;
            ResultSrc  = RES_ALURESULT;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_FOUR;
            ALUOp      = ALUOP_ADD;
        end
    end

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed table-driven bench for main_fsm, plus a hand-written
// sequence for reset asserted in the middle of a store.
module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic       Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .Branch(Branch), .PCUpdate(PCUpdate), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Branch,PCUpdate,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal_op}
    logic [14:0] act;
    assign act = {Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op};

    typedef struct packed {
        logic        rst;
        logic [6:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [14:0] out;
    } vec_t;

    localparam int NV = 35;
    vec_t vt [NV];

    function automatic logic [14:0] pk(input logic br, pc, rw, mw, ir, adr,
                                       input logic [1:0] res, sa, sb, aop,
                                       input logic ill);
        return {br, pc, rw, mw, ir, adr, res, sa, sb, aop, ill};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [6:0] o, input logic mr,
                                input logic [3:0] st, input logic [14:0] out);
        vec_t v;
        v.rst = rst; v.op = o; v.mr = mr; v.st = st; v.out = out;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [14:0] a, input logic [14:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s [%0d]: got %b expected %b", name, idx, a, e);
        end
    endtask

    logic [14:0] o_rst, o_f1, o_f0, o_dec, o_ill, o_madr, o_mrd, o_mwb, o_mw1, o_mw0;
    logic [14:0] o_exr, o_exi, o_awb, o_beq, o_jal;

    initial begin
        o_rst  = pk(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0);
        o_f1   = pk(0,1,0,0,1,0, 2'b10,2'b00,2'b10,2'b00, 0);
        o_f0   = o_rst;
        o_dec  = pk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0);
        o_ill  = pk(0,0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 1);
        o_madr = pk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0);
        o_mrd  = pk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0);
        o_mwb  = pk(0,0,1,0,0,0, 2'b01,2'b00,2'b00,2'b00, 0);
        o_mw1  = pk(0,0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00, 0);
        o_mw0  = pk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0);
        o_exr  = pk(0,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0);
        o_exi  = pk(0,0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10, 0);
        o_awb  = pk(0,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0);
        o_beq  = pk(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b01, 0);
        o_jal  = pk(0,1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0);

        // One row per cycle: inputs held for the cycle, outputs checked mid-cycle.
        vt[0]  = mk(0, 7'b0000011, 1, 4'd0,  o_rst);   // reset
        vt[1]  = mk(1, 7'b0000011, 1, 4'd0,  o_f1);    // lw: 5 cycles
        vt[2]  = mk(1, 7'b0000011, 0, 4'd1,  o_dec);   // mem_ready ignored
        vt[3]  = mk(1, 7'b0000011, 1, 4'd2,  o_madr);
        vt[4]  = mk(1, 7'b0000011, 1, 4'd3,  o_mrd);
        vt[5]  = mk(1, 7'b0000011, 0, 4'd4,  o_mwb);
        vt[6]  = mk(1, 7'b0100011, 0, 4'd0,  o_f0);    // fetch stall
        vt[7]  = mk(1, 7'b0100011, 1, 4'd0,  o_f1);    // sw with 3 stall cycles
        vt[8]  = mk(1, 7'b0100011, 1, 4'd1,  o_dec);
        vt[9]  = mk(1, 7'b0100011, 1, 4'd2,  o_madr);
        vt[10] = mk(1, 7'b0100011, 0, 4'd5,  o_mw0);
        vt[11] = mk(1, 7'b0100011, 0, 4'd5,  o_mw0);
        vt[12] = mk(1, 7'b0100011, 0, 4'd5,  o_mw0);
        vt[13] = mk(1, 7'b0100011, 1, 4'd5,  o_mw1);
        vt[14] = mk(1, 7'b0110011, 1, 4'd0,  o_f1);    // R-type
        vt[15] = mk(1, 7'b0110011, 0, 4'd1,  o_dec);
        vt[16] = mk(1, 7'b0110011, 0, 4'd6,  o_exr);
        vt[17] = mk(1, 7'b0110011, 1, 4'd8,  o_awb);
        vt[18] = mk(1, 7'b0010011, 1, 4'd0,  o_f1);    // I-type
        vt[19] = mk(1, 7'b0010011, 1, 4'd1,  o_dec);
        vt[20] = mk(1, 7'b0010011, 1, 4'd7,  o_exi);
        vt[21] = mk(1, 7'b0010011, 1, 4'd8,  o_awb);
        vt[22] = mk(1, 7'b1100011, 1, 4'd0,  o_f1);    // beq: 3 cycles
        vt[23] = mk(1, 7'b1100011, 1, 4'd1,  o_dec);
        vt[24] = mk(1, 7'b1100011, 1, 4'd9,  o_beq);
        vt[25] = mk(1, 7'b1101111, 1, 4'd0,  o_f1);    // jal
        vt[26] = mk(1, 7'b1101111, 1, 4'd1,  o_dec);
        vt[27] = mk(1, 7'b1101111, 1, 4'd10, o_jal);
        vt[28] = mk(1, 7'b1101111, 1, 4'd8,  o_awb);
        vt[29] = mk(1, 7'b1111111, 1, 4'd0,  o_f1);    // illegal opcode
        vt[30] = mk(1, 7'b1111111, 1, 4'd1,  o_ill);
        vt[31] = mk(1, 7'b1111111, 0, 4'd0,  o_f0);
        vt[32] = mk(1, 7'b1111111, 0, 4'd0,  o_f0);
        vt[33] = mk(1, 7'b1111111, 1, 4'd0,  o_f1);
        vt[34] = mk(1, 7'b0110011, 1, 4'd1,  o_dec);   // pulse gone after one cycle

        reset = 1'b0; op = '0; mem_ready = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            reset = vt[i].rst; op = vt[i].op; mem_ready = vt[i].mr;
            @(negedge clk);
            chk("state", i, {11'd0, state}, {11'd0, vt[i].st});
            chk("outputs", i, act, vt[i].out);
            @(posedge clk); #1;
        end

        // Reset in the middle of a store with mem_ready high.
        reset = 1'b0; #2; reset = 1'b1;
        op = 7'b0100011; mem_ready = 1'b1;
        repeat (3) @(posedge clk);               // FETCH -> DECODE -> MEMADR -> MEMWRITE
        #1;
        @(negedge clk);
        chk("mw_state", 100, {11'd0, state}, 15'd5);
        chk("mw_strobe", 101, {14'd0, MemWrite}, 15'd1);
        #1 reset = 1'b0;                         // async, no clock edge
        #1;
        chk("rst_state", 102, {11'd0, state}, 15'd0);
        chk("rst_outputs", 103, act, o_rst);
        @(posedge clk); #1;
        chk("rst_hold_outputs", 104, act, o_rst);
        chk("rst_hold_state", 105, {11'd0, state}, 15'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rst_fetch", 106, act, o_f1);
        @(posedge clk); #1;
        chk("post_rst_decode", 107, {11'd0, state}, 15'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
